// File: rtl/snn_result_pkg.sv
// Shared constants, state encoding and frame helpers for the SNN result return path.
package snn_result_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [6:0] NO_WINNER = 7'h7F;

  localparam int unsigned IDX_HEADER = 0;
  localparam int unsigned IDX_COUNT0 = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FLUSH,
    ST_SEND,
    ST_DRAIN
  } state_t;

  // Number of 32-bit raster words needed for a given step count.
  function automatic int unsigned spike_words(input int unsigned steps, input int unsigned n);
    return (steps * n + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/snn_result_tx_if.sv
// Capture and host handshake signals of the result return path.
interface snn_result_tx_if #(
  parameter int unsigned N_NEURONS = 2
);
  logic                 start;
  logic                 spike_valid;
  logic [N_NEURONS-1:0] spikes;
  logic                 done;
  logic                 next;
  logic [31:0]          data;
  logic                 valid;
  logic                 last;
  logic                 busy;
  logic                 overflow;

  modport master (
    output start, spike_valid, spikes, done, next,
    input  data, valid, last, busy, overflow
  );

  modport slave (
    input  start, spike_valid, spikes, done, next,
    output data, valid, last, busy, overflow
  );
endinterface

// File: rtl/snn_spike_packer.sv
// Packs N-bit spike vectors LSB-first into 32-bit words; flush emits a zero-padded partial word.
module snn_spike_packer #(
  parameter int unsigned N_NEURONS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 flush,
  input  logic [N_NEURONS-1:0] vec,
  output logic [31:0]          word,
  output logic                 word_valid
);
  localparam int unsigned PER_WORD = 32 / N_NEURONS;
  localparam int unsigned FILL_W   = (PER_WORD > 1) ? $clog2(PER_WORD) : 1;

  logic [31:0]       acc;
  logic [FILL_W-1:0] fill;
  logic [31:0]       placed;
  logic              full;

  assign placed = 32'(vec) << (N_NEURONS * 32'(fill));
  assign full   = (32'(fill) == PER_WORD - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc        <= '0;
      fill       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (shift) begin
        if (full) begin
          word       <= acc | placed;
          word_valid <= 1'b1;
          acc        <= '0;
          fill       <= '0;
        end else begin
          acc  <= acc | placed;
          fill <= fill + 1'b1;
        end
      end else if (flush && fill != '0) begin
        word       <= acc;
        word_valid <= 1'b1;
        acc        <= '0;
        fill       <= '0;
      end
    end
  end
endmodule

// File: rtl/snn_result_tx.sv
// Captures one inference's output spikes and counts, then streams header/counts/raster to the host.
module snn_result_tx
  import snn_result_pkg::*;
#(
  parameter int unsigned N_NEURONS = 2,
  parameter int unsigned MAX_STEPS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input logic            clk,
  input logic            rst,
  snn_result_tx_if.slave bus
);
  localparam int unsigned DEPTH  = MAX_STEPS * N_NEURONS / 32;
  localparam int unsigned BUF_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
  localparam int unsigned PTR_W  = $clog2(IDX_COUNT0 + N_NEURONS + DEPTH + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt [N_NEURONS];
  logic [STEP_W-1:0] step_cnt;
  logic [BUF_AW:0]   wr_ptr;
  logic [31:0]       spk_buf [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  last_idx;
  logic [6:0]        winner_q;
  logic              next_d;
  logic              next_dd;
  logic              rise;
  logic              accept;
  logic [31:0]       pk_word;
  logic              pk_valid;
  logic [31:0]       frame_word;
  logic [6:0]        win_c;
  logic [CNT_W-1:0]  best_c;

  logic [31:0] data_q;
  logic        valid_q;
  logic        last_q;
  logic        busy_q;
  logic        ovf_q;

  assign bus.data     = data_q;
  assign bus.valid    = valid_q;
  assign bus.last     = last_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

  assign rise   = next_d & ~next_dd;
  assign accept = (state == ST_CAPTURE) && bus.spike_valid && (32'(step_cnt) < MAX_STEPS);

  snn_spike_packer #(.N_NEURONS(N_NEURONS)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == ST_IDLE && bus.start),
    .shift      (accept),
    .flush      (state == ST_FLUSH),
    .vec        (bus.spikes),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_ff @(posedge clk) begin
    if (pk_valid && 32'(wr_ptr) < DEPTH) spk_buf[wr_ptr[BUF_AW-1:0]] <= pk_word;
  end

  // Strict '>' keeps the lowest index on ties; a zero best means nobody fired.
  always_comb begin
    best_c = '0;
    win_c  = NO_WINNER;
    for (int unsigned k = 0; k < N_NEURONS; k++) begin
      if (cnt[k] > best_c) begin
        best_c = cnt[k];
        win_c  = 7'(k);
      end
    end
  end

  always_comb begin
    frame_word = '0;
    if (32'(ptr) == IDX_HEADER) begin
      frame_word = {HDR_MAGIC, ovf_q, winner_q, 16'(step_cnt)};
    end else if (32'(ptr) < IDX_COUNT0 + N_NEURONS) begin
      for (int unsigned k = 0; k < N_NEURONS; k++)
        if (32'(ptr) == IDX_COUNT0 + k) frame_word = 32'(cnt[k]);
    end else begin
      frame_word = spk_buf[BUF_AW'(32'(ptr) - IDX_COUNT0 - N_NEURONS)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      wr_ptr   <= '0;
      ptr      <= '0;
      last_idx <= '0;
      winner_q <= '0;
      next_d   <= 1'b0;
      next_dd  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int unsigned k = 0; k < N_NEURONS; k++) cnt[k] <= '0;
    end else begin
      next_d  <= bus.next;
      next_dd <= next_d;
      if (pk_valid && 32'(wr_ptr) < DEPTH) wr_ptr <= wr_ptr + 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_CAPTURE;
            busy_q   <= 1'b1;
            step_cnt <= '0;
            wr_ptr   <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned k = 0; k < N_NEURONS; k++) cnt[k] <= '0;
          end
        end

        ST_CAPTURE: begin
          if (accept) begin
            step_cnt <= step_cnt + 1'b1;
            for (int unsigned k = 0; k < N_NEURONS; k++)
              if (bus.spikes[k] && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
          end else if (bus.spike_valid) begin
            ovf_q <= 1'b1;
          end
          if (bus.done) state <= ST_FLUSH;
        end

        ST_FLUSH: begin
          winner_q <= win_c;
          last_idx <= PTR_W'(IDX_COUNT0 + N_NEURONS + spike_words(32'(step_cnt), N_NEURONS) - 1);
          ptr      <= '0;
          state    <= ST_SEND;
        end

        ST_SEND: begin
          // Output registers trail ptr by one cycle, so a new word settles two cycles after the edge.
          data_q  <= frame_word;
          valid_q <= 1'b1;
          last_q  <= (ptr == last_idx);
          if (rise) begin
            if (ptr == last_idx) begin
              state   <= ST_DRAIN;
              data_q  <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (!next_d) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_snn_result_tx.sv
// Directed bench for snn_result_tx: capture, frame readout, overflow, races and reset abort.
module tb_snn_result_tx;
  localparam int unsigned N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  snn_result_tx_if #(.N_NEURONS(N)) bus ();

  snn_result_tx #(.N_NEURONS(N), .MAX_STEPS(256), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] expw [0:31];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic step(input logic [1:0] v);
    bus.spike_valid = 1'b1;
    bus.spikes      = v;
    tick();
    bus.spike_valid = 1'b0;
    bus.spikes      = '0;
  endtask

  task automatic done_pulse();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic read_frame(input int n, input int nread, input int start_at);
    int k;
    for (int i = 0; i < nread; i++) begin
      k = 0;
      while (bus.valid !== 1'b1 && k < 50) begin
        tick();
        k++;
      end
      check($sformatf("valid_w%0d", i), 32'(bus.valid), 32'd1);
      check($sformatf("data_w%0d", i), bus.data, expw[i]);
      check($sformatf("last_w%0d", i), 32'(bus.last), (i == n - 1) ? 32'd1 : 32'd0);
      if (i == start_at) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
      end
      bus.next = 1'b1;
      tick();
      tick();
      if (i == n - 1) begin
        check("drain_valid", 32'(bus.valid), 32'd0);
        check("drain_last", 32'(bus.last), 32'd0);
        check("drain_busy", 32'(bus.busy), 32'd1);
      end
      bus.next = 1'b0;
      tick();
      tick();
      tick();
    end
    if (nread == n) check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic set_basic();
    expw[0] = 32'hA500_0003;
    expw[1] = 32'd2;
    expw[2] = 32'd2;
    expw[3] = 32'h0000_0039;
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.spike_valid = 1'b0;
    bus.spikes      = '0;
    bus.done        = 1'b0;
    bus.next        = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_data", bus.data, 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_last", 32'(bus.last), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);

    // basic frame
    start_pulse();
    check("cap_busy", 32'(bus.busy), 32'd1);
    step(2'b01);
    step(2'b10);
    step(2'b11);
    done_pulse();
    set_basic();
    read_frame(4, 4, -1);

    // overflow
    start_pulse();
    repeat (257) step(2'b01);
    done_pulse();
    check("ovf_set", 32'(bus.overflow), 32'd1);
    expw[0] = 32'hA580_0100;
    expw[1] = 32'd256;
    expw[2] = 32'd0;
    for (int i = 3; i < 19; i++) expw[i] = 32'h5555_5555;
    read_frame(19, 19, -1);

    // no spikes
    start_pulse();
    check("ovf_cleared", 32'(bus.overflow), 32'd0);
    repeat (5) step(2'b00);
    done_pulse();
    expw[0] = 32'hA57F_0005;
    expw[1] = 32'd0;
    expw[2] = 32'd0;
    expw[3] = 32'd0;
    read_frame(4, 4, -1);

    // empty inference
    start_pulse();
    done_pulse();
    expw[0] = 32'hA57F_0000;
    expw[1] = 32'd0;
    expw[2] = 32'd0;
    read_frame(3, 3, -1);

    // spike_valid together with done
    start_pulse();
    step(2'b01);
    bus.spike_valid = 1'b1;
    bus.spikes      = 2'b10;
    bus.done        = 1'b1;
    tick();
    bus.spike_valid = 1'b0;
    bus.spikes      = '0;
    bus.done        = 1'b0;
    expw[0] = 32'hA500_0002;
    expw[1] = 32'd1;
    expw[2] = 32'd1;
    expw[3] = 32'h0000_0009;
    read_frame(4, 4, -1);

    // start together with done in IDLE
    bus.start = 1'b1;
    bus.done  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.done  = 1'b0;
    check("race_busy", 32'(bus.busy), 32'd1);
    repeat (5) tick();
    check("race_not_sending", 32'(bus.valid), 32'd0);
    step(2'b11);
    done_pulse();
    expw[0] = 32'hA500_0001;
    expw[1] = 32'd1;
    expw[2] = 32'd1;
    expw[3] = 32'h0000_0003;
    read_frame(4, 4, -1);

    // start during SEND is ignored
    start_pulse();
    step(2'b01);
    step(2'b10);
    step(2'b11);
    done_pulse();
    set_basic();
    read_frame(4, 4, 1);

    // reset while word 2 is presented
    start_pulse();
    step(2'b01);
    step(2'b10);
    step(2'b11);
    done_pulse();
    set_basic();
    read_frame(4, 2, -1);
    check("pre_rst_word2", bus.data, expw[2]);
    rst = 1'b1;
    tick();
    check("abort_data", bus.data, 32'd0);
    check("abort_valid", 32'(bus.valid), 32'd0);
    check("abort_last", 32'(bus.last), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    tick();
    start_pulse();
    step(2'b11);
    step(2'b11);
    step(2'b01);
    done_pulse();
    expw[0] = 32'hA500_0003;
    expw[1] = 32'd3;
    expw[2] = 32'd2;
    expw[3] = 32'h0000_001F;
    read_frame(4, 4, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/snn_result_tx.md
Name: snn_result_tx

Overview:
Return path from the spiking network to the JTAG host. It captures the per-timestep spike vector of the output neurons during one inference and keeps a spike count per neuron. When the inference ends it streams a result frame to the host as 32-bit words: header, per-neuron counts, then packed spike raster. The host pulls the frame one word at a time with a level NEXT handshake, the mirror of the host-to-fabric image upload.

Parameters:
N_NEURONS, 2, number of output neurons; 1..32, power of two.
MAX_STEPS, 256, timesteps stored per inference; N_NEURONS*MAX_STEPS is a multiple of 32.
CNT_W, 16, spike-counter width, at most 32.

Ports:
iCLK  in  1  main fabric clock (120 MHz domain).
iRESET  in  1  synchronous reset, active-high.
iSTART  in  1  single-cycle pulse that begins capture of a new inference.
iSPIKE_VALID  in  1  one pulse per network timestep.
iSPIKES  in  N_NEURONS  spike vector, sampled when iSPIKE_VALID is high; bit k is neuron k.
iDONE  in  1  pulse marking the end of the inference.
iNEXT  in  1  host level; each rising edge acknowledges the current word.
oDATA  out  32  current frame word.
oVALID  out  1  oDATA holds a frame word.
oLAST  out  1  oDATA is the final frame word.
oBUSY  out  1  high in every state except IDLE.
oOVERFLOW  out  1  sticky: more than MAX_STEPS timesteps were seen in this inference.

Behaviour:
- Reset: state IDLE; all outputs 0; counters, step count and pointers cleared. Reset mid-capture or mid-send aborts; no partial frame is resumed.
- States: IDLE, CAPTURE, FLUSH, SEND, DRAIN.
- IDLE:
  - iSTART goes to CAPTURE and clears counters, step count, packer and oOVERFLOW.
  - iDONE and iSPIKE_VALID are ignored.
  - If iSTART and iDONE arrive together, start wins.
- CAPTURE:
  - On iSPIKE_VALID with step < MAX_STEPS: iSPIKES is shifted into the packer LSB-first, so step s lands at bits [N*(s mod 32/N) +: N] of its word.
  - Each counter k increments on bit k and saturates at all-ones.
  - The step count increments.
  - Each full 32-bit word is written to the spike buffer, depth MAX_STEPS*N/32.
  - On iSPIKE_VALID with step >= MAX_STEPS: sample dropped, oOVERFLOW set, counts and steps frozen.
  - iDONE goes to FLUSH. If iSPIKE_VALID is high in the same cycle, that sample is captured first.
  - iSTART is ignored.
- FLUSH (1 cycle):
  - A partial packer word is written zero-padded; if empty, nothing is written.
  - Winner is computed: lowest index with the maximum count, or 7'h7F if all counts are 0.
  - Goes to SEND with the read pointer at 0.
- Frame contents:
  - Word 0 = {8'hA5, oOVERFLOW, winner[6:0], step_count[15:0]}.
  - Words 1..N = counts zero-extended to 32 bits.
  - Then ceil(steps*N/32) spike words.
- SEND:
  - oVALID=1, oDATA=frame[ptr], oLAST=(ptr==last).
  - iNEXT goes through a registered edge detector. A rising edge sampled at cycle t advances ptr at t+1; the new oDATA is stable from t+2.
  - Further edges during that window are honoured, one advance each.
  - A rising edge while oLAST=1 goes to DRAIN with oVALID and oLAST at 0.
- DRAIN: waits for iNEXT=0, then goes to IDLE.
- iSTART is ignored in FLUSH, SEND and DRAIN.

Decomposition:
- Package snn_result_pkg holds:
  - HDR_MAGIC=8'hA5 and NO_WINNER=7'h7F.
  - Frame word-index constants.
  - The state enum typedef.
- One sub-module, snn_spike_packer: shift-accumulates N-bit vectors into 32-bit words and reports word_valid and a partial flush.

Test Plan:
- Basic frame, N=2: 3 steps of iSPIKES 01, 10, 11, then iDONE → frame 0xA5000003, 2, 2, 0x00000039; oLAST on the 4th word; DRAIN; oBUSY falls after iNEXT=0.
- Overflow: 257 steps of 01 → header 0xA5800100; count0=256, count1=0; 16 spike words of 0x55555555; oOVERFLOW=1.
- No spikes: 5 steps of 00 → header 0xA57F0005, counts 0, 0, one spike word 0x00000000.
- Empty inference: iSTART immediately followed by iDONE → 3 words (0xA57F0000, 0, 0); oLAST on word 2.
- Races:
  - iSPIKE_VALID together with iDONE captures the last sample.
  - iSTART together with iDONE in IDLE enters CAPTURE.
  - iSTART during SEND leaves the frame unchanged.
- Reset mid-SEND at word 2 → all outputs 0 next cycle; a fresh inference produces a correct frame.
